// File: rtl/mc_main_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, alu_op,
// alu_src_b and pc_source codes, control-state encoding and the opcode dispatch.
package mc_main_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // aluControlUnit decodes these same alu_op values.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REGB    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_START, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
    ST_EXEC, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_EX, ST_ADDI_WB, ST_ILLEGAL
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return ST_MEM_ADDR;
      OP_RTYPE:     return ST_EXEC;
      OP_BEQ:       return ST_BRANCH;
      OP_J:         return ST_JUMP;
      OP_ADDI:      return ST_ADDI_EX;
      default:      return ST_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_main_control_fsm.sv
// Multicycle MIPS main control. Outputs decode the state register so reset
// clears every control asynchronously; FETCH IR/PC loads are qualified by mem_ready.
module mc_main_control_fsm
  import mc_main_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_START;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_START:    w_next = ST_FETCH;
      ST_FETCH:    if (mem_ready) w_next = ST_DECODE;
      ST_DECODE:   w_next = decode_next(opcode);
      ST_MEM_ADDR: w_next = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) w_next = ST_MEM_WB;
      ST_MEM_WR:   if (mem_ready) w_next = ST_FETCH;
      ST_EXEC:     w_next = ST_R_WB;
      ST_ADDI_EX:  w_next = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB, ST_ILLEGAL:
                   w_next = ST_FETCH;
      default:     w_next = ST_START;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = ALUSRCB_FOUR;
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_write  = mem_ready;
      end
      ST_DECODE:   w_ctrl.alu_src_b = ALUSRCB_IMM_SH2;
      ST_MEM_ADDR, ST_ADDI_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUSRCB_IMM;
      end
      ST_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
      end
      ST_ADDI_WB:  w_ctrl.reg_write  = 1'b1;
      ST_ILLEGAL:  w_ctrl.illegal_op = 1'b1;
      default:     w_ctrl = '0;
    endcase
  end

  assign alu_op        = w_ctrl.alu_op;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign pc_source     = w_ctrl.pc_source;
  assign reg_dst       = w_ctrl.reg_dst;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_write     = w_ctrl.reg_write;
  assign illegal_op    = w_ctrl.illegal_op;

endmodule

// File: tb/tb_mc_main_control_fsm.sv
// Bench for mc_main_control_fsm: each opcode expands into its list of micro-steps,
// and every cycle the DUT controls are compared against that step's control word.
module tb_mc_main_control_fsm;

  localparam logic [5:0] T_RTYPE = 6'h00, T_LW = 6'h23, T_SW = 6'h2B;
  localparam logic [5:0] T_BEQ = 6'h04, T_J = 6'h02, T_ADDI = 6'h08;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MRD = 3, S_MWB = 4;
  localparam int S_MWR = 5, S_EXEC = 6, S_RWB = 7, S_BR = 8, S_JMP = 9;
  localparam int S_AEX = 10, S_AWB = 11, S_ILL = 12;

  logic       clk, rst_n, mem_ready;
  logic [5:0] opcode;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic       alu_src_a, i_or_d, mem_read, mem_write, ir_write, pc_write;
  logic       pc_write_cond, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [16:0] w_obs;

  int n_chk = 0;
  int n_pass = 0;

  mc_main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal_op(illegal_op)
  );

  assign w_obs = {alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write, ir_write,
                  pc_write, pc_write_cond, pc_source, reg_dst, mem_to_reg, reg_write,
                  illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %05h, expected %05h", tag, obs, exp);
  endtask

  // Control word a micro-step must present; mr only matters for the FETCH loads.
  function automatic logic [16:0] step_ctrl(input int s, input logic mr);
    logic [1:0] aop, asb, pcs;
    logic asa, iod, mrd, mwr, irw, pcw, pcc, rd, m2r, rw, ill;
    {aop, asb, pcs} = '0;
    {asa, iod, mrd, mwr, irw, pcw, pcc, rd, m2r, rw, ill} = '0;
    case (s)
      S_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: asb = 2'b11;
      S_MADDR:  begin asa = 1; asb = 2'b10; end
      S_MRD:    begin mrd = 1; iod = 1; end
      S_MWB:    begin rw = 1; m2r = 1; end
      S_MWR:    begin mwr = 1; iod = 1; end
      S_EXEC:   begin asa = 1; aop = 2'b10; end
      S_RWB:    begin rw = 1; rd = 1; end
      S_BR:     begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      S_JMP:    begin pcw = 1; pcs = 2'b10; end
      S_AEX:    begin asa = 1; asb = 2'b10; end
      S_AWB:    rw = 1;
      default:  ill = 1;
    endcase
    return {aop, asa, asb, iod, mrd, mwr, irw, pcw, pcc, pcs, rd, m2r, rw, ill};
  endfunction

  function automatic bit is_stall_step(input int s);
    return (s == S_FETCH) || (s == S_MRD) || (s == S_MWR);
  endfunction

  // Drive one cycle's inputs, compare mid-cycle, then advance past the next edge.
  task automatic step(input string tag, input int s, input logic mr, input logic [5:0] op);
    mem_ready = mr;
    opcode    = op;
    @(negedge clk);
    chk_val(tag, w_obs, step_ctrl(s, mr));
    @(posedge clk);
    #1;
  endtask

  // stall < 0 picks a random 0..2 wait-state count for each stallable step.
  task automatic run_instr(input string tag, input logic [5:0] op, input int stall);
    int seq[$];
    int k;
    seq = '{S_FETCH, S_DECODE};
    case (op)
      T_LW:    seq = {seq, S_MADDR, S_MRD, S_MWB};
      T_SW:    seq = {seq, S_MADDR, S_MWR};
      T_RTYPE: seq = {seq, S_EXEC, S_RWB};
      T_BEQ:   seq.push_back(S_BR);
      T_J:     seq.push_back(S_JMP);
      T_ADDI:  seq = {seq, S_AEX, S_AWB};
      default: seq.push_back(S_ILL);
    endcase
    foreach (seq[i]) begin
      if (is_stall_step(seq[i])) begin
        k = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        for (int j = 0; j < k; j++)
          step(tag, seq[i], 1'b0, (seq[i] == S_FETCH) ? 6'($urandom) : op);
        step(tag, seq[i], 1'b1, (seq[i] == S_FETCH) ? 6'($urandom) : op);
      end else begin
        step(tag, seq[i], 1'($urandom), op);
      end
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6];
    logic [5:0] o;
    legal = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
    if ($urandom_range(0, 5) != 0) return legal[$urandom_range(0, 5)];
    do o = 6'($urandom); while (o inside {T_RTYPE, T_LW, T_SW, T_BEQ, T_J, T_ADDI});
    return o;
  endfunction

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = '0;
    repeat (3) begin
      @(posedge clk);
      mem_ready = 1'($urandom);
      opcode = 6'($urandom);
    end
    @(negedge clk);
    chk_val("reset_hold", w_obs, 17'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk_val("start_idle", w_obs, 17'h0);
    @(posedge clk);
    #1;

    run_instr("rtype", T_RTYPE, 0);
    run_instr("lw_stall2", T_LW, 2);
    run_instr("sw", T_SW, 0);
    run_instr("beq", T_BEQ, 0);
    run_instr("jump", T_J, 0);
    run_instr("addi", T_ADDI, 1);
    run_instr("illegal_3f", 6'h3F, 0);

    for (int n = 0; n < 80; n++) run_instr("rand", pick_op(), -1);

    step("mid_fetch", S_FETCH, 1'b1, 6'($urandom));
    step("mid_decode", S_DECODE, 1'b1, T_SW);
    step("mid_maddr", S_MADDR, 1'b1, T_SW);
    mem_ready = 1'b0;
    @(negedge clk);
    chk_val("mid_memwr", w_obs, step_ctrl(S_MWR, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    chk_val("rst_async_mem_write", {16'h0, mem_write}, 17'h0);
    chk_val("rst_async_all", w_obs, 17'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_val("rst_held_after_abort", w_obs, 17'h0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk_val("restart_idle", w_obs, 17'h0);
    @(posedge clk);
    #1;
    run_instr("after_reset", T_BEQ, 0);
    run_instr("after_reset", T_LW, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
